// File: rtl/mips_single_cycle.sv
// -----------------------------------------------------------------------------
// mips_single_cycle
//   Single-cycle 32-bit MIPS core. It fetches, decodes, executes and writes back
//   one instruction on every rising edge of clk_CPU. The core has no external
//   bus. The instruction memory (IM.instBank), the register bank
//   (BR.registerBank) and the data memory (DM.dataMemory) are preloaded by the
//   environment, and reset never clears them.
//
//   Ports
//     clk_CPU    in   1   single clock, all state changes on its rising edge
//     rst_CPU_n  in   1   asynchronous active-low reset (PC and resultado -> 0)
//     resultado  out  32  registered write-back value of the last retired
//                         instruction that wrote a register
//
//   Supported: add sub and or nor slt | addi slti andi ori lw sw | beq bne j.
//   Any other opcode or funct executes as a NOP and advances PC by 4.
// -----------------------------------------------------------------------------

// Instruction ROM with a combinational read. The index wraps modulo DEPTH.
//   idx_i   in   word index (PC[AW+1:2])
//   instr_o out  instruction word
module mips_im #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0] idx_i,
  output logic [31:0]   instr_o
);
  logic [31:0] instBank [DEPTH];

  assign instr_o = instBank[idx_i];
endmodule

// 32x32 register bank: two combinational read ports and one write port.
// The write port updates the bank on the rising clock edge.
//   ra1_i/ra2_i  read addresses      rd1_o/rd2_o  read data ($0 reads 0)
//   we_i/wa_i    write enable/addr   wd_i         write data
module mips_rf (
  input  logic        clk_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] registerBank [32];

  // Reads ignore the stored $0 entry. A write in this cycle is seen only by
  // the next instruction, because the bank updates at the edge.
  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : registerBank[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : registerBank[ra2_i];

  // NOTE: storage arrays carry no reset; the caller qualifies we_i with reset
  // instead, so contents survive reset exactly as preloaded.
  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) begin
      registerBank[wa_i] <= wd_i;
    end
  end
endmodule

// Word-addressed data memory: combinational read, write on the rising edge.
//   idx_i  word index     we_i  write enable
//   wd_i   write data     rd_o  read data
module mips_dm #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);
  logic [31:0] dataMemory [DEPTH];

  assign rd_o = dataMemory[idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      dataMemory[idx_i] <= wd_i;
    end
  end
endmodule

module mips_single_cycle #(
  parameter int IM_DEPTH = 256,
  parameter int DM_DEPTH = 256
) (
  input  logic        clk_CPU,
  input  logic        rst_CPU_n,
  output logic [31:0] resultado
);
  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
  } alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] resultado_q, resultado_d;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  logic [31:0] rs_val, rt_val, dm_rdata;
  logic [31:0] imm_sext, imm_zext, alu_b, alu_res, wb_data;
  logic [31:0] pc_plus4, br_target;

  // Decode controls
  alu_op_e     alu_op;
  logic        reg_we, dst_rd, use_imm, imm_zero_ext;
  logic        is_lw, is_sw, is_beq, is_bne, is_j;

  // ---------------------------------------------------------------- fetch
  mips_im #(.DEPTH(IM_DEPTH)) IM (
    .idx_i   (pc_q[IM_AW+1:2]),
    .instr_o (instr)
  );

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  // --------------------------------------------------------------- decode
  // NOTE: every always_comb output gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    dst_rd       = 1'b0;
    use_imm      = 1'b0;
    imm_zero_ext = 1'b0;
    is_lw        = 1'b0;
    is_sw        = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_j         = 1'b0;
    unique case (op)
      6'h00: begin
        dst_rd = 1'b1;
        reg_we = 1'b1;
        unique case (funct)
          6'h20:   alu_op = ALU_ADD;
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h27:   alu_op = ALU_NOR;
          6'h2A:   alu_op = ALU_SLT;
          default: reg_we = 1'b0;  // unknown funct: NOP
        endcase
      end
      6'h08: begin reg_we = 1'b1; use_imm = 1'b1; end
      6'h0A: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT; end
      6'h0C: begin reg_we = 1'b1; use_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_AND; end
      6'h0D: begin reg_we = 1'b1; use_imm = 1'b1; imm_zero_ext = 1'b1; alu_op = ALU_OR; end
      6'h23: begin reg_we = 1'b1; use_imm = 1'b1; is_lw = 1'b1; end
      6'h2B: begin use_imm = 1'b1; is_sw = 1'b1; end
      6'h04: is_beq = 1'b1;
      6'h05: is_bne = 1'b1;
      6'h02: is_j   = 1'b1;
      default: ;                  // unknown opcode: NOP
    endcase
  end

  // ------------------------------------------------------- register bank
  // Writes are suppressed while reset is held, so a store or write-back
  // caught under reset is dropped.
  mips_rf BR (
    .clk_i (clk_CPU),
    .ra1_i (rs),
    .ra2_i (rt),
    .we_i  (reg_we & rst_CPU_n),
    .wa_i  (dst_rd ? rd : rt),
    .wd_i  (wb_data),
    .rd1_o (rs_val),
    .rd2_o (rt_val)
  );

  // ------------------------------------------------------------------ ALU
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'd0, imm};
  assign alu_b    = use_imm ? (imm_zero_ext ? imm_zext : imm_sext) : rt_val;

  always_comb begin
    unique case (alu_op)
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_NOR: alu_res = ~(rs_val | alu_b);
      ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(alu_b)};
      default: alu_res = rs_val + alu_b;
    endcase
  end

  // ---------------------------------------------------------- data memory
  // Address bits [1:0] are dropped, so lw/sw always act on whole words.
  mips_dm #(.DEPTH(DM_DEPTH)) DM (
    .clk_i (clk_CPU),
    .we_i  (is_sw & rst_CPU_n),
    .idx_i (alu_res[DM_AW+1:2]),
    .wd_i  (rt_val),
    .rd_o  (dm_rdata)
  );

  assign wb_data = is_lw ? dm_rdata : alu_res;

  // -------------------------------------------------------------- next PC
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};

  always_comb begin
    if (is_j) begin
      pc_d = {pc_plus4[31:28], target, 2'b00};
    end else if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))) begin
      pc_d = br_target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // resultado keeps its value for instructions that write no register.
  assign resultado_d = reg_we ? wb_data : resultado_q;

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples values from before the edge, as real flops do.
  always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
    if (!rst_CPU_n) begin
      pc_q        <= 32'd0;
      resultado_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      resultado_q <= resultado_d;
    end
  end

  assign resultado = resultado_q;

endmodule

// File: tb/tb_mips_single_cycle.sv
// -----------------------------------------------------------------------------
// tb_mips_single_cycle
//   Bench for mips_single_cycle. It preloads a short program into
//   IM.instBank. While it loads, it pushes the expected next PC and resultado
//   for each instruction onto a scoreboard queue. After every rising edge it
//   pops one entry and compares it with the core. The run covers reset, the
//   ALU, memory, branches, a jump, $0 handling, NOPs and a reset during a store.
// -----------------------------------------------------------------------------
module tb_mips_single_cycle;

  logic        clk_CPU = 1'b0;
  logic        rst_CPU_n = 1'b0;
  logic [31:0] resultado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];

  mips_single_cycle #(.IM_DEPTH(256), .DM_DEPTH(256)) dut (
    .clk_CPU   (clk_CPU),
    .rst_CPU_n (rst_CPU_n),
    .resultado (resultado)
  );

  always #5 clk_CPU = ~clk_CPU;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input logic [5:0] funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Place an instruction and queue what the core must show after it retires.
  task automatic put(input int addr, input logic [31:0] instr, input string tag,
                     input logic [31:0] next_pc, input logic [31:0] res);
    exp_t e;
    dut.IM.instBank[addr / 4] = instr;
    e.tag = tag;
    e.pc  = next_pc;
    e.res = res;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;

    // Slots 0x14/0x18 must be skipped by the taken beq.
    dut.IM.instBank[5] = enc_i(6'h08, 0, 20, 16'h0066);
    dut.IM.instBank[6] = enc_i(6'h08, 0, 20, 16'h0066);

    put(32'h00, enc_i(6'h08, 0, 1, 16'd5),        "addi1",   32'h04, 32'd5);
    put(32'h04, enc_i(6'h08, 0, 2, 16'd7),        "addi2",   32'h08, 32'd7);
    put(32'h08, enc_r(1, 2, 3, 6'h20),            "add",     32'h0C, 32'd12);
    put(32'h0C, enc_r(1, 2, 4, 6'h22),            "sub",     32'h10, 32'hFFFF_FFFE);
    put(32'h10, enc_i(6'h04, 0, 0, 16'd2),        "beq",     32'h1C, 32'hFFFF_FFFE);
    put(32'h1C, enc_r(1, 2, 5, 6'h2A),            "slt",     32'h20, 32'd1);
    put(32'h20, enc_i(6'h05, 0, 0, 16'd2),        "bne",     32'h24, 32'd1);
    put(32'h24, enc_i(6'h08, 0, 1, 16'd8),        "addi8",   32'h28, 32'd8);
    put(32'h28, enc_i(6'h2B, 0, 1, 16'd4),        "sw",      32'h2C, 32'd8);
    put(32'h2C, enc_i(6'h23, 0, 2, 16'd4),        "lw",      32'h30, 32'd8);
    put(32'h30, enc_i(6'h0D, 0, 6, 16'hF0F0),     "ori",     32'h34, 32'h0000_F0F0);
    put(32'h34, enc_i(6'h0C, 4, 7, 16'h8001),     "andi",    32'h38, 32'h0000_8000);
    put(32'h38, enc_i(6'h08, 0, 8, 16'hFFFF),     "addi_m1", 32'h3C, 32'hFFFF_FFFF);
    put(32'h3C, enc_i(6'h0A, 8, 9, 16'd0),        "slti",    32'h40, 32'd1);
    put(32'h40, enc_r(2, 8, 10, 6'h2A),           "slt_neg", 32'h44, 32'd0);
    put(32'h44, enc_r(6, 8, 11, 6'h24),           "and",     32'h48, 32'h0000_F0F0);
    put(32'h48, enc_r(6, 4, 12, 6'h25),           "or",      32'h4C, 32'hFFFF_FFFE);
    put(32'h4C, enc_r(6, 0, 13, 6'h27),           "nor",     32'h50, 32'hFFFF_0F0F);
    put(32'h50, enc_i(6'h08, 0, 0, 16'd9),        "addi_r0", 32'h54, 32'd9);
    put(32'h54, enc_r(0, 3, 14, 6'h20),           "add_r0",  32'h58, 32'd12);
    put(32'h58, enc_r(1, 2, 3, 6'h3F),            "nop_fn",  32'h5C, 32'd12);
    put(32'h5C, enc_i(6'h3F, 1, 2, 16'h1234),     "nop_op",  32'h60, 32'd12);
    put(32'h60, enc_i(6'h08, 0, 15, 16'd3),       "rbw1",    32'h64, 32'd3);
    put(32'h64, enc_i(6'h08, 15, 15, 16'd4),      "rbw2",    32'h68, 32'd7);
    put(32'h68, enc_i(6'h23, 0, 17, 16'd7),       "lw_unal", 32'h6C, 32'd8);
    put(32'h6C, enc_j(26'h000040),                "j",       32'h100, 32'd8);
    put(32'h100, enc_i(6'h2B, 0, 0, 16'd12),      "sw_zero", 32'h104, 32'd8);
    put(32'h104, enc_i(6'h08, 0, 16, 16'h0055),   "addi55",  32'h108, 32'h0000_0055);
    // Store that the mid-run reset must cancel.
    dut.IM.instBank[32'h108 / 4] = enc_i(6'h2B, 0, 16, 16'd12);

    // Reset held over three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_CPU); #1;
      check("rst_pc", dut.pc_q, 32'd0);
      check("rst_res", resultado, 32'd0);
    end

    @(negedge clk_CPU);
    rst_CPU_n = 1'b1;

    // One pop per retired instruction; the loop is bounded by the queue size.
    while (sb_q.size() > 0) begin
      @(posedge clk_CPU); #1;
      e = sb_q.pop_front();
      check({e.tag, "_pc"}, dut.pc_q, e.pc);
      check({e.tag, "_res"}, resultado, e.res);
    end

    check("reg3",  dut.BR.registerBank[3],  32'd12);
    check("reg2",  dut.BR.registerBank[2],  32'd8);
    check("reg15", dut.BR.registerBank[15], 32'd7);
    check("reg16", dut.BR.registerBank[16], 32'h0000_0055);
    check("reg17", dut.BR.registerBank[17], 32'd8);
    check("dm1",   dut.DM.dataMemory[1],    32'd8);
    check("dm3",   dut.DM.dataMemory[3],    32'd0);

    // Mid-run reset between edges while the store at 0x108 is current.
    @(negedge clk_CPU);
    rst_CPU_n = 1'b0;
    #1;
    check("mid_rst_pc", dut.pc_q, 32'd0);
    check("mid_rst_res", resultado, 32'd0);
    repeat (2) @(posedge clk_CPU);
    #1;
    check("mid_rst_dm3", dut.DM.dataMemory[3], 32'd0);
    check("mid_rst_pc_hold", dut.pc_q, 32'd0);

    // After release, instBank[0] retires on the next edge.
    @(negedge clk_CPU);
    rst_CPU_n = 1'b1;
    @(posedge clk_CPU); #1;
    check("rel_pc", dut.pc_q, 32'h04);
    check("rel_res", resultado, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
